// File: rtl/in_channel.sv
// in_channel: input stream buffer feeding the program's "in" instruction.
// A producer pushes words (wrValid/wrReady, wrLast closes the stream) into a
// circular buffer. Each rdReq is answered one cycle later with exactly one of
// rdAck (word delivered), rdEmpty (no data yet, stream open) or rdEnd (stream
// closed and fully drained).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   LOADING  | stream open, producer may still write
//   CLOSED   | final word accepted, buffered words remain to be read
//   DRAINED  | final word accepted and every word has been read
module in_channel #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wrValid,
    input  logic [MemoryElementWidth-1:0] wrData,
    input  logic                          wrLast,
    output logic                          wrReady,
    input  logic                          rdReq,
    output logic [MemoryElementWidth-1:0] rdData,
    output logic                          rdAck,
    output logic                          rdEmpty,
    output logic                          rdEnd,
    output logic [$clog2(NIn+1)-1:0]      count
);

    localparam int CW = $clog2(NIn + 1);
    localparam int PW = (NIn > 1) ? $clog2(NIn) : 1;

    localparam logic [CW-1:0] DEPTH    = CW'(NIn);
    localparam logic [PW-1:0] LAST_POS = PW'(NIn - 1);

    localparam logic [1:0] ST_LOADING = 2'd0;
    localparam logic [1:0] ST_CLOSED  = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [1:0]                    state_q,    state_d;
    logic [CW-1:0]                 count_q,    count_d;
    logic [PW-1:0]                 wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q,   rd_ptr_d;
    logic [MemoryElementWidth-1:0] rd_data_q,  rd_data_d;
    logic                          rd_ack_q,   rd_ack_d;
    logic                          rd_empty_q, rd_empty_d;
    logic                          rd_end_q,   rd_end_d;

    logic [MemoryElementWidth-1:0] mem_q [NIn];

    logic wr_ready;
    logic wr_fire;
    logic rd_fire;
    logic buf_empty;

    // Handshake qualifiers; readiness looks only at registered state so a read
    // in the same cycle never opens space early.
    always_comb begin
        buf_empty = (count_q == '0);
        wr_ready  = (state_q == ST_LOADING) && (count_q < DEPTH);
        wr_fire   = wrValid && wr_ready;
        rd_fire   = rdReq && !buf_empty;
    end

    // Pointer, occupancy, state and response next-state logic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_ack_d   = 1'b0;
        rd_empty_d = 1'b0;
        rd_end_d   = 1'b0;

        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_POS) ? '0 : wr_ptr_q + 1'b1;
        end

        if (rd_fire) begin
            rd_ptr_d  = (rd_ptr_q == LAST_POS) ? '0 : rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
            rd_ack_d  = 1'b1;
        end else if (rdReq) begin
            // Empty buffer: the answer depends on whether more data can still come.
            rd_empty_d = (state_q == ST_LOADING);
            rd_end_d   = (state_q != ST_LOADING);
        end

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_LOADING: begin
                if (wr_fire && wrLast) begin
                    state_d = (count_d == '0) ? ST_DRAINED : ST_CLOSED;
                end
            end
            ST_CLOSED: begin
                if (count_d == '0) begin
                    state_d = ST_DRAINED;
                end
            end
            ST_DRAINED: state_d = ST_DRAINED;
            default:    state_d = ST_LOADING;
        endcase
    end

    // Control and response registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOADING;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            rd_empty_q <= 1'b0;
            rd_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_ack_d;
            rd_empty_q <= rd_empty_d;
            rd_end_q   <= rd_end_d;
        end
    end

    // Word storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wrData;
        end
    end

    // Output drive.
    always_comb begin
        wrReady = wr_ready;
        rdData  = rd_data_q;
        rdAck   = rd_ack_q;
        rdEmpty = rd_empty_q;
        rdEnd   = rd_end_q;
        count   = count_q;
    end

endmodule

// File: tb/tb_in_channel.sv
// Scoreboard bench for in_channel (NIn=4): a FIFO-level reference model predicts
// each response; a separate monitor pops and compares at the response cycle.
module tb_in_channel;

    localparam int W = 12;
    localparam int N = 4;

    logic           clock   = 1'b0;
    logic           reset   = 1'b0;
    logic           wrValid = 1'b0;
    logic [W-1:0]   wrData  = '0;
    logic           wrLast  = 1'b0;
    logic           rdReq   = 1'b0;
    logic           wrReady;
    logic [W-1:0]   rdData;
    logic           rdAck;
    logic           rdEmpty;
    logic           rdEnd;
    logic [2:0]     count;

    in_channel #(.MemoryElementWidth(W), .NIn(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .wrValid (wrValid),
        .wrData  (wrData),
        .wrLast  (wrLast),
        .wrReady (wrReady),
        .rdReq   (rdReq),
        .rdData  (rdData),
        .rdAck   (rdAck),
        .rdEmpty (rdEmpty),
        .rdEnd   (rdEnd),
        .count   (count)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int           kind;   // 0 ack, 1 empty, 2 end
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] mbuf [$];
    bit           mclosed = 1'b0;
    logic [W-1:0] hold_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check handshake/occupancy, predict outcome.
    task automatic step(input bit wv, input logic [W-1:0] wd, input bit wl, input bit rq);
        exp_t e;
        bit   ready_exp;
        wrValid = wv;
        wrData  = wd;
        wrLast  = wl;
        rdReq   = rq;
        #1;
        ready_exp = !mclosed && (mbuf.size() < N);
        chk("wrReady", 32'(wrReady), 32'(ready_exp));
        chk("count", 32'(count), 32'(mbuf.size()));
        if (rq) begin
            e.due = edge_cnt + 1;
            if (mbuf.size() > 0) begin
                e.kind = 0;
                e.data = mbuf.pop_front();
            end else begin
                e.kind = mclosed ? 2 : 1;
                e.data = '0;
            end
            sb.push_back(e);
        end
        if (wv && ready_exp) begin
            mbuf.push_back(wd);
            if (wl) mclosed = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    // Reset asserted between edges; everything buffered or in flight is lost.
    task automatic mid_reset();
        #1;
        reset   = 1'b0;
        wrValid = 1'b0;
        wrLast  = 1'b0;
        rdReq   = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdAck", 32'(rdAck), 32'd0);
        chk("rst_rdEmpty", 32'(rdEmpty), 32'd0);
        chk("rst_rdEnd", 32'(rdEnd), 32'd0);
        chk("rst_rdData", 32'(rdData), 32'd0);
        sb.delete();
        mbuf.delete();
        mclosed = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: responses must appear exactly on the cycle the scoreboard says.
    initial begin
        exp_t e;
        int   nresp;
        int   kind_act;
        forever begin
            @(negedge clock);
            if (!reset) begin
                hold_data = '0;
            end else begin
                nresp = int'(rdAck) + int'(rdEmpty) + int'(rdEnd);
                chk("resp_onehot", 32'(nresp <= 1), 32'd1);
                if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                    e = sb.pop_front();
                    kind_act = rdAck ? 0 : rdEmpty ? 1 : rdEnd ? 2 : 3;
                    chk("resp_kind", 32'(kind_act), 32'(e.kind));
                    if (e.kind == 0) begin
                        chk("rdData", 32'(rdData), 32'(e.data));
                        hold_data = e.data;
                    end else begin
                        chk("rdData_hold", 32'(rdData), 32'(hold_data));
                    end
                end else begin
                    chk("spurious_resp", 32'(nresp), 32'd0);
                    chk("rdData_idle", 32'(rdData), 32'(hold_data));
                end
            end
        end
    end

    initial begin
        int rd_pct;
        #12;
        chk("init_count", 32'(count), 32'd0);
        chk("init_rdAck", 32'(rdAck), 32'd0);
        chk("init_rdEmpty", 32'(rdEmpty), 32'd0);
        chk("init_rdEnd", 32'(rdEnd), 32'd0);
        chk("init_rdData", 32'(rdData), 32'd0);
        reset = 1'b1;

        // Three-word stream, drained, then one request past the end.
        step(1'b1, 12'd11, 1'b0, 1'b0);
        step(1'b1, 12'd22, 1'b0, 1'b0);
        step(1'b1, 12'd33, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 12'd44, 1'b0, 1'b0);
        idle(2);

        // Empty read while loading, then a single word.
        mid_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 12'd5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Fill to capacity, reject extra, read while full, space next cycle.
        for (int i = 0; i < 4; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0);
        step(1'b1, 12'd104, 1'b0, 1'b0);
        step(1'b1, 12'd105, 1'b0, 1'b1);
        step(1'b1, 12'd106, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Ten words with simultaneous reads across pointer wraps.
        mid_reset();
        for (int c = 0; c < 14; c++) step(c < 10, W'(c), c == 9, c >= 2);
        idle(1);

        // Last word written together with a read on an empty buffer.
        mid_reset();
        step(1'b1, 12'd77, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Reset with words buffered and a request in flight.
        mid_reset();
        step(1'b1, 12'd1, 1'b0, 1'b0);
        step(1'b1, 12'd2, 1'b0, 1'b0);
        step(1'b1, 12'd3, 1'b0, 1'b1);
        mid_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Randomized traffic with varying read pressure and occasional resets.
        rd_pct = 30;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) rd_pct = $urandom_range(10, 90);
            if ((mclosed && mbuf.size() == 0 && ($urandom_range(0, 7) == 0)) ||
                ($urandom_range(0, 299) == 0)) begin
                mid_reset();
            end
            step(($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < rd_pct));
        end
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
